// File: rtl/hilo_if.sv
// -----------------------------------------------------------------------------
// hilo_if
// Execute-stage bundle between the pipeline and the HI/LO unit.
//   master (pipeline): drives valid, op, in0, in1, alu_result, alu_result_high;
//                      receives stall, busy, hilo_out, div_zero
//   slave  (hilo_unit): the mirror image
// -----------------------------------------------------------------------------
interface hilo_if;
    logic        valid;            // instruction present in execute
    logic [4:0]  op;               // ALU op code
    logic [31:0] in0;              // rs operand: dividend, MTHI/MTLO source
    logic [31:0] in1;              // rt operand: divisor
    logic [31:0] alu_result;       // low product word from the ALU
    logic [31:0] alu_result_high;  // high product word from the ALU
    logic        stall;            // hold execute stage this cycle
    logic        busy;             // divider iterating
    logic [31:0] hilo_out;         // MFHI/MFLO read data
    logic        div_zero;         // pulse after a zero-divisor accept

    modport master (
        output valid, op, in0, in1, alu_result, alu_result_high,
        input  stall, busy, hilo_out, div_zero
    );

    modport slave (
        input  valid, op, in0, in1, alu_result, alu_result_high,
        output stall, busy, hilo_out, div_zero
    );
endinterface

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
// HI/LO register pair plus a 32-iteration restoring divider for the MIPS
// execute stage. Multiply products from the ALU and MTHI/MTLO sources are
// written directly; divides run for 32 step cycles plus one sign-fix cycle
// while busy is held and later HI/LO-class instructions are stalled.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : hilo_if.slave (valid/op/operands in; stall/busy/hilo_out/div_zero out)
// -----------------------------------------------------------------------------
module hilo_unit (
    input  logic   clk,
    input  logic   rst,
    hilo_if.slave  bus
);

    localparam logic [4:0] OP_MULTS = 5'd2;
    localparam logic [4:0] OP_MULTU = 5'd3;
    localparam logic [4:0] OP_MFHI  = 5'd20;
    localparam logic [4:0] OP_MFLO  = 5'd21;
    localparam logic [4:0] OP_DIVS  = 5'd25;
    localparam logic [4:0] OP_DIVU  = 5'd26;
    localparam logic [4:0] OP_MTHI  = 5'd27;
    localparam logic [4:0] OP_MTLO  = 5'd28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_FIX
    } state_e;

    state_e      state_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [32:0] rem_q;      // partial remainder (one guard bit for the shift)
    logic [31:0] quo_q;      // dividend shifts out of the top, quotient bits in at the bottom
    logic [31:0] dvsr_q;     // divisor magnitude
    logic [4:0]  cnt_q;      // iteration counter, 31 down to 0
    logic        q_neg_q;    // negate quotient in FIX
    logic        r_neg_q;    // negate remainder in FIX
    logic        busy_q;
    logic        div_zero_q;

    logic        is_hilo;
    logic        accept;
    logic [31:0] abs_in0;
    logic [31:0] abs_in1;
    logic [32:0] rem_shift;
    logic [32:0] rem_sub;
    logic [32:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] hilo_out_d;

    always_comb begin
        unique case (bus.op)
            OP_MULTS, OP_MULTU, OP_MFHI, OP_MFLO,
            OP_DIVS, OP_DIVU, OP_MTHI, OP_MTLO: is_hilo = 1'b1;
            default:                            is_hilo = 1'b0;
        endcase
    end

    // busy_q is high exactly while the FSM is out of IDLE, so accepting only
    // when !busy_q also means accepts happen only in IDLE.
    assign accept    = bus.valid && is_hilo && !busy_q;
    assign bus.stall = bus.valid && is_hilo && busy_q;

    // Signed divides iterate on magnitudes; 0x80000000 negates to itself,
    // which is the correct unsigned magnitude 2^31.
    assign abs_in0 = (bus.op == OP_DIVS && bus.in0[31]) ? (32'd0 - bus.in0) : bus.in0;
    assign abs_in1 = (bus.op == OP_DIVS && bus.in1[31]) ? (32'd0 - bus.in1) : bus.in1;

    // One restoring step: shift in the next dividend bit and subtract the
    // divisor; a set bit 32 on the difference means it went negative, so the
    // shifted value is kept and a 0 quotient bit is produced.
    assign rem_shift = {rem_q[31:0], quo_q[31]};
    assign rem_sub   = rem_shift - {1'b0, dvsr_q};

    always_comb begin
        if (rem_sub[32]) begin
            rem_d = rem_shift;
            quo_d = {quo_q[30:0], 1'b0};
        end else begin
            rem_d = rem_sub;
            quo_d = {quo_q[30:0], 1'b1};
        end
    end

    // NOTE: every always_comb output gets a value on every path (default
    // first) so no latch is inferred.
    always_comb begin
        hilo_out_d = 32'd0;
        if (bus.op == OP_MFHI) hilo_out_d = hi_q;
        if (bus.op == OP_MFLO) hilo_out_d = lo_q;
    end

    assign bus.hilo_out = hilo_out_d;
    assign bus.busy     = busy_q;
    assign bus.div_zero = div_zero_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            rem_q      <= 33'd0;
            quo_q      <= 32'd0;
            dvsr_q     <= 32'd0;
            cnt_q      <= 5'd0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            div_zero_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            OP_MULTS, OP_MULTU: begin
                                hi_q <= bus.alu_result_high;
                                lo_q <= bus.alu_result;
                            end
                            OP_MTHI: hi_q <= bus.in0;
                            OP_MTLO: lo_q <= bus.in0;
                            OP_DIVS, OP_DIVU: begin
                                if (bus.in1 == 32'd0) begin
                                    hi_q       <= bus.in0;
                                    lo_q       <= 32'hFFFF_FFFF;
                                    div_zero_q <= 1'b1;
                                end else begin
                                    rem_q   <= 33'd0;
                                    quo_q   <= abs_in0;
                                    dvsr_q  <= abs_in1;
                                    q_neg_q <= (bus.op == OP_DIVS) && (bus.in0[31] ^ bus.in1[31]);
                                    r_neg_q <= (bus.op == OP_DIVS) && bus.in0[31];
                                    cnt_q   <= 5'd31;
                                    busy_q  <= 1'b1;
                                    state_q <= ST_DIV;
                                end
                            end
                            default: ; // MFHI/MFLO are pure reads
                        endcase
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == 5'd0) begin
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                ST_FIX: begin
                    lo_q    <= q_neg_q ? (32'd0 - quo_q) : quo_q;
                    hi_q    <= r_neg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
// Self-checking bench for hilo_unit. A behavioural model computes HI/LO and
// divide results with plain arithmetic and tracks the busy window as a cycle
// count; a compare process checks every DUT output on every falling edge.
// Directed sequences with literal expectations pin the model, then random
// traffic exercises the rest.
// -----------------------------------------------------------------------------
module tb_hilo_unit;

    localparam logic [4:0] OP_ADD   = 5'd0;   // any non-HI/LO code
    localparam logic [4:0] OP_MULTS = 5'd2;
    localparam logic [4:0] OP_MULTU = 5'd3;
    localparam logic [4:0] OP_MFHI  = 5'd20;
    localparam logic [4:0] OP_MFLO  = 5'd21;
    localparam logic [4:0] OP_DIVS  = 5'd25;
    localparam logic [4:0] OP_DIVU  = 5'd26;
    localparam logic [4:0] OP_MTHI  = 5'd27;
    localparam logic [4:0] OP_MTLO  = 5'd28;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_if bus ();

    hilo_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_hilo(input logic [4:0] op);
        return op inside {OP_MULTS, OP_MULTU, OP_MFHI, OP_MFLO,
                          OP_DIVS, OP_DIVU, OP_MTHI, OP_MTLO};
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi, m_lo;      // architectural HI/LO
    logic [31:0] p_hi, p_lo;      // divide result waiting for its writeback
    int          m_left = 0;      // busy cycles remaining
    bit          m_dz   = 1'b0;

    always @(posedge clk) begin : model
        bit     acc;
        longint a, b;
        if (rst) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
            m_dz   = 1'b0;
        end else begin
            acc  = bus.valid && is_hilo(bus.op) && (m_left == 0);
            m_dz = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end
            if (acc) begin
                case (bus.op)
                    OP_MULTS, OP_MULTU: begin
                        m_hi = bus.alu_result_high;
                        m_lo = bus.alu_result;
                    end
                    OP_MTHI: m_hi = bus.in0;
                    OP_MTLO: m_lo = bus.in0;
                    OP_DIVS, OP_DIVU: begin
                        if (bus.in1 == 32'd0) begin
                            m_hi = bus.in0;
                            m_lo = 32'hFFFF_FFFF;
                            m_dz = 1'b1;
                        end else begin
                            if (bus.op == OP_DIVU) begin
                                p_lo = bus.in0 / bus.in1;
                                p_hi = bus.in0 % bus.in1;
                            end else begin
                                a    = $signed(bus.in0);
                                b    = $signed(bus.in1);
                                p_lo = 32'(a / b);   // truncates toward zero
                                p_hi = 32'(a % b);   // sign follows dividend
                            end
                            m_left = 33;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin : compare
        logic        e_busy, e_stall;
        logic [31:0] e_out;
        if (chk_en) begin
            e_busy  = (m_left > 0);
            e_stall = bus.valid && e_busy && is_hilo(bus.op);
            e_out   = (bus.op == OP_MFHI) ? m_hi : (bus.op == OP_MFLO) ? m_lo : 32'd0;
            check("busy",     32'(bus.busy),     32'(e_busy));
            check("stall",    32'(bus.stall),    32'(e_stall));
            check("div_zero", 32'(bus.div_zero), 32'(m_dz));
            check("hilo_out", bus.hilo_out,      e_out);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [4:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ph, input logic [31:0] pl);
        @(posedge clk);
        #1;
        bus.valid           = v;
        bus.op              = o;
        bus.in0             = a;
        bus.in1             = b;
        bus.alu_result_high = ph;
        bus.alu_result      = pl;
    endtask

    task automatic idle();
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic read_hilo(input logic [4:0] o, input string name, input logic [31:0] exp);
        drive(1'b1, o, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        check(name, bus.hilo_out, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            idle();
            @(negedge clk);
            n++;
        end while (bus.busy && n < 60);
        check("wait_idle_bound", 32'(bus.busy), 32'd0);
    endtask

    logic [4:0]  ops [10] = '{OP_MULTS, OP_MULTU, OP_MFHI, OP_MFLO, OP_DIVS,
                              OP_DIVU, OP_MTHI, OP_MTLO, OP_ADD, 5'd9};
    logic [31:0] specials [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd7};

    function automatic logic [31:0] rand_operand();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int nb, n_st;
        logic [31:0] d;

        rst = 1'b1;
        bus.valid = 1'b0; bus.op = OP_ADD; bus.in0 = '0; bus.in1 = '0;
        bus.alu_result = '0; bus.alu_result_high = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state.
        read_hilo(OP_MFHI, "reset_mfhi", 32'd0);
        check("reset_busy",  32'(bus.busy),  32'd0);
        check("reset_stall", 32'(bus.stall), 32'd0);
        read_hilo(OP_MFLO, "reset_mflo", 32'd0);

        // MULTU capture.
        drive(1'b1, OP_MULTU, 32'd0, 32'd0, 32'h0000_0001, 32'hFFFF_FFFE);
        read_hilo(OP_MFHI, "multu_hi", 32'h0000_0001);
        read_hilo(OP_MFLO, "multu_lo", 32'hFFFF_FFFE);

        // DIVS -7 / 2 with busy window length.
        drive(1'b1, OP_DIVS, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            @(negedge clk);
            if (bus.busy) nb++;
        end
        check("divs_busy_cycles", 32'(nb), 32'd33);
        read_hilo(OP_MFLO, "divs_m7_2_lo", 32'hFFFF_FFFD);
        read_hilo(OP_MFHI, "divs_m7_2_hi", 32'hFFFF_FFFF);

        // DIVU same operands.
        drive(1'b1, OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        wait_idle();
        read_hilo(OP_MFLO, "divu_lo", 32'h7FFF_FFFC);
        read_hilo(OP_MFHI, "divu_hi", 32'h0000_0001);

        // DIVU 100/7: ADD passes in T+1, MFLO from T+5 stalls until T+34.
        drive(1'b1, OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0);
        drive(1'b1, OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0);
        @(negedge clk);
        check("add_no_stall", 32'(bus.stall), 32'd0);
        check("add_busy",     32'(bus.busy),  32'd1);
        repeat (3) idle();
        n_st = 0;
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, OP_MFLO, 32'd0, 32'd0, 32'd0, 32'd0);
            @(negedge clk);
            if (!bus.stall) break;
            n_st++;
        end
        check("mflo_stall_cycles", 32'(n_st), 32'd29);
        check("divu_100_7_lo", bus.hilo_out, 32'd14);
        read_hilo(OP_MFHI, "divu_100_7_hi", 32'd2);

        // Divide by zero.
        drive(1'b1, OP_DIVS, 32'h0000_1234, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("dz_no_busy",    32'(bus.busy),     32'd0);
        idle();
        @(negedge clk);
        check("dz_pulse",      32'(bus.div_zero), 32'd1);
        check("dz_busy_after", 32'(bus.busy),     32'd0);
        idle();
        @(negedge clk);
        check("dz_pulse_end",  32'(bus.div_zero), 32'd0);
        read_hilo(OP_MFHI, "dz_hi", 32'h0000_1234);
        read_hilo(OP_MFLO, "dz_lo", 32'hFFFF_FFFF);

        // Most-negative / -1.
        drive(1'b1, OP_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
        wait_idle();
        read_hilo(OP_MFLO, "ovf_lo", 32'h8000_0000);
        read_hilo(OP_MFHI, "ovf_hi", 32'd0);

        // MTHI, then reset aborts a divide at T+10.
        drive(1'b1, OP_MTHI, 32'h0000_AAAA, 32'd0, 32'd0, 32'd0);
        read_hilo(OP_MFHI, "mthi", 32'h0000_AAAA);
        drive(1'b1, OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0);
        repeat (9) idle();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        read_hilo(OP_MFHI, "abort_hi", 32'd0);
        read_hilo(OP_MFLO, "abort_lo", 32'd0);
        repeat (40) idle();
        read_hilo(OP_MFHI, "abort_no_wb_hi", 32'd0);
        read_hilo(OP_MFLO, "abort_no_wb_lo", 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            d = ($urandom_range(0, 5) == 0) ? 32'd0 : rand_operand();
            drive($urandom_range(0, 4) != 0, ops[$urandom_range(0, 9)],
                  rand_operand(), d, $urandom, $urandom);
            rst = ($urandom_range(0, 399) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
